vtg_pattern_gen: RTL and testbench

VTG_PATTERN_GEN -- requirements
Module: vtg_pattern_gen

---
 rtl/vtg_pattern_gen.sv | 159 +++++++++++++++
 tb/tb_vtg_pattern_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vtg_pattern_gen.sv
// Video timing generator with built-in test patterns (solid, colour bars, ramp, checker).
// All outputs are registered one clock after the counter state they describe.
module vtg_pattern_gen #(
    parameter int unsigned HACT   = 640,
    parameter int unsigned HFP    = 16,
    parameter int unsigned HSP    = 96,
    parameter int unsigned HBP    = 48,
    parameter int unsigned VACT   = 480,
    parameter int unsigned VFP    = 10,
    parameter int unsigned VSP    = 2,
    parameter int unsigned VBP    = 33,
    parameter int unsigned DW     = 8,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0
) (
    input  logic              px_clk,
    input  logic              sys_rst,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [3*DW-1:0]   color_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              dval_o,
    output logic              sof_o,
    output logic              eol_o,
    output logic [DW-1:0]     rdata_o,
    output logic [DW-1:0]     gdata_o,
    output logic [DW-1:0]     bdata_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int unsigned HTOTAL = HACT + HFP + HSP + HBP;
    localparam int unsigned VTOTAL = VACT + VFP + VSP + VBP;
    localparam int unsigned HW     = (HTOTAL > 1) ? $clog2(HTOTAL) : 1;
    localparam int unsigned VW     = (VTOTAL > 1) ? $clog2(VTOTAL) : 1;

    logic [HW-1:0]   hcnt_reg, hcnt_next;
    logic [VW-1:0]   vcnt_reg, vcnt_next;
    logic [31:0]     hx, vx;
    logic            h_wrap, v_wrap, at_origin;
    logic [1:0]      mode_reg, mode_sel;
    logic [3*DW-1:0] color_reg, color_sel;
    logic [7:1]      bar_ge;
    logic [2:0]      bar_idx;
    logic            active, hs_on, vs_on;
    logic [DW-1:0]   full, ramp;
    logic [DW-1:0]   r_next, g_next, b_next;

    assign hx   = 32'(hcnt_reg);
    assign vx   = 32'(vcnt_reg);
    assign full = '1;
    assign ramp = DW'(hcnt_reg);

    // Bar k starts at k*HACT/8; the bar index is how many starts lie at or before hcnt.
    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_bar
            localparam int unsigned BOUND = (32'(gi) * HACT) / 8;
            assign bar_ge[gi] = (hx >= BOUND);
        end
    endgenerate

    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[i]};
        end
    end

    always_comb begin
        h_wrap    = (hx == HTOTAL - 1);
        v_wrap    = (vx == VTOTAL - 1);
        at_origin = (hcnt_reg == '0) && (vcnt_reg == '0);
        hcnt_next = h_wrap ? '0 : hcnt_reg + HW'(1);
        vcnt_next = vcnt_reg;
        if (h_wrap) begin
            vcnt_next = v_wrap ? '0 : vcnt_reg + VW'(1);
        end
        // Pixel (0,0) already uses the values being captured, so a whole frame is consistent.
        mode_sel  = at_origin ? mode_i  : mode_reg;
        color_sel = at_origin ? color_i : color_reg;
        active    = (hx < HACT) && (vx < VACT);
        hs_on     = (hx >= HACT + HFP) && (hx < HACT + HFP + HSP);
        vs_on     = (vx >= VACT + VFP) && (vx < VACT + VFP + VSP);
        r_next    = '0;
        g_next    = '0;
        b_next    = '0;
        if (active) begin
            case (mode_sel)
                2'd0: {r_next, g_next, b_next} = color_sel;
                2'd1: begin
                    r_next = bar_idx[1] ? '0 : full;
                    g_next = bar_idx[2] ? '0 : full;
                    b_next = bar_idx[0] ? '0 : full;
                end
                2'd2: begin
                    r_next = ramp;
                    g_next = ramp;
                    b_next = ramp;
                end
                default: begin
                    if (hx[5] ^ vx[5]) begin
                        r_next = full;
                        g_next = full;
                        b_next = full;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge px_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hcnt_reg    <= '0;
            vcnt_reg    <= '0;
            mode_reg    <= '0;
            color_reg   <= '0;
            dval_o      <= 1'b0;
            sof_o       <= 1'b0;
            eol_o       <= 1'b0;
            hsync_o     <= ~HS_POL;
            vsync_o     <= ~VS_POL;
            rdata_o     <= '0;
            gdata_o     <= '0;
            bdata_o     <= '0;
            frame_cnt_o <= '0;
        end else if (!en_i) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
            dval_o   <= 1'b0;
            sof_o    <= 1'b0;
            eol_o    <= 1'b0;
            hsync_o  <= ~HS_POL;
            vsync_o  <= ~VS_POL;
            rdata_o  <= '0;
            gdata_o  <= '0;
            bdata_o  <= '0;
        end else begin
            hcnt_reg <= hcnt_next;
            vcnt_reg <= vcnt_next;
            if (at_origin) begin
                mode_reg  <= mode_i;
                color_reg <= color_i;
            end
            dval_o  <= active;
            sof_o   <= active && at_origin;
            eol_o   <= active && (hx == HACT - 1);
            hsync_o <= hs_on ? HS_POL : ~HS_POL;
            vsync_o <= vs_on ? VS_POL : ~VS_POL;
            rdata_o <= r_next;
            gdata_o <= g_next;
            bdata_o <= b_next;
            if (h_wrap && v_wrap) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vtg_pattern_gen.sv
// Scoreboard bench: a pixel-position reference model predicts every output cycle,
// a negedge monitor pops and compares against the registered DUT outputs.
module tb_vtg_pattern_gen;

    localparam int unsigned HACT = 80, HFP = 3, HSP = 5, HBP = 4;
    localparam int unsigned VACT = 70, VFP = 2, VSP = 3, VBP = 2;
    localparam int unsigned DW = 8;
    localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
    localparam int HTOT  = HACT + HFP + HSP + HBP;
    localparam int VTOT  = VACT + VFP + VSP + VBP;
    localparam int FRAME = HTOT * VTOT;

    logic clk = 1'b0;
    logic sys_rst;
    logic en_i;
    logic [1:0] mode_i;
    logic [23:0] color_i;
    logic hsync_o, vsync_o, dval_o, sof_o, eol_o;
    logic [7:0] rdata_o, gdata_o, bdata_o;
    logic [15:0] frame_cnt_o;

    vtg_pattern_gen #(
        .HACT(HACT), .HFP(HFP), .HSP(HSP), .HBP(HBP),
        .VACT(VACT), .VFP(VFP), .VSP(VSP), .VBP(VBP),
        .DW(DW), .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .px_clk(clk), .sys_rst(sys_rst), .en_i(en_i), .mode_i(mode_i), .color_i(color_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .dval_o(dval_o), .sof_o(sof_o), .eol_o(eol_o),
        .rdata_o(rdata_o), .gdata_o(gdata_o), .bdata_o(bdata_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        logic [44:0] v;   // {hs, vs, dval, sof, eol, rgb[23:0], frame[15:0]}
    } exp_t;

    exp_t exp_q[$];
    int edge_n = 0;
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Reference model state: pixel position, captured pattern, completed frames.
    int          mh, mv;
    logic [1:0]  cmode;
    logic [23:0] ccol;
    logic [15:0] mframe;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [44:0] observed();
        return {hsync_o, vsync_o, dval_o, sof_o, eol_o, rdata_o, gdata_o, bdata_o, frame_cnt_o};
    endfunction

    function automatic logic [44:0] reset_vals();
        return {~HS_POL, ~VS_POL, 3'b000, 24'h0, 16'h0};
    endfunction

    task automatic check(input string name, input int edge_no, input logic [44:0] got,
                         input logic [44:0] want);
        checks++;
        if (got === want) begin
            passed++;
        end else begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s edge=%0d got=%h want=%h (hs,vs,dv,sof,eol,rgb,fc)",
                         name, edge_no, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
            e = exp_q.pop_front();
            check("stale", e.edge_no, 45'h0, e.v);
        end
        if (exp_q.size() > 0 && exp_q[0].edge_no == edge_n) begin
            e = exp_q.pop_front();
            check("pixel", e.edge_no, observed(), e.v);
        end
    end

    function automatic void model_reset();
        mh = 0; mv = 0; cmode = 2'd0; ccol = 24'h0; mframe = 16'h0;
    endfunction

    // Predict the outputs after the next edge given the inputs about to be sampled.
    function automatic logic [44:0] model_step(input logic en, input logic [1:0] mode,
                                               input logic [23:0] col);
        logic [1:0]  m;
        logic [23:0] c, rgb;
        logic [7:0]  rb;
        logic act, hs, vs, sof, eol;
        int k;
        if (!en) begin
            mh = 0; mv = 0;
            return {~HS_POL, ~VS_POL, 3'b000, 24'h0, mframe};
        end
        if (mh == 0 && mv == 0) begin
            cmode = mode;
            ccol  = col;
        end
        m = cmode; c = ccol;
        act = (mh < HACT) && (mv < VACT);
        hs  = (mh >= HACT + HFP && mh < HACT + HFP + HSP) ? HS_POL : ~HS_POL;
        vs  = (mv >= VACT + VFP && mv < VACT + VFP + VSP) ? VS_POL : ~VS_POL;
        sof = act && mh == 0 && mv == 0;
        eol = act && mh == HACT - 1;
        rgb = 24'h0;
        if (act) begin
            case (m)
                2'd0: rgb = c;
                2'd1: begin
                    k = 0;
                    for (int j = 1; j < 8; j++) if (mh >= j * HACT / 8) k = j;
                    rgb = bars[k];
                end
                2'd2: begin
                    rb = 8'(mh % 256);
                    rgb = {rb, rb, rb};
                end
                default: rgb = ((((mh / 32) ^ (mv / 32)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            endcase
        end
        if (mh == HTOT - 1 && mv == VTOT - 1) mframe = mframe + 16'd1;
        mh = mh + 1;
        if (mh == HTOT) begin
            mh = 0;
            mv = (mv + 1) % VTOT;
        end
        return {hs, vs, act, sof, eol, rgb, mframe};
    endfunction

    task automatic step(input logic en, input logic [1:0] mode, input logic [23:0] col);
        exp_t e;
        en_i = en; mode_i = mode; color_i = col;
        e.edge_no = edge_n + 1;
        e.v = model_step(en, mode, col);
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic hold_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.edge_no = edge_n + 1;
            e.v = reset_vals();
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    // Reset asserted between edges: outputs must collapse before the next edge.
    task automatic reset_mid();
        exp_t e;
        #2 sys_rst = 1'b1;
        #1 check("async_reset", edge_n, observed(), reset_vals());
        exp_q.delete();
        e.edge_no = edge_n;
        e.v = reset_vals();
        exp_q.push_back(e);
        model_reset();
        @(posedge clk); #1;
        hold_reset(2);
        sys_rst = 1'b0;
    endtask

    task automatic phase_done(input string name);
        $display("phase %s: checks=%0d passed=%0d frame_cnt=%0d", name, checks, passed, frame_cnt_o);
    endtask

    initial begin
        logic [1:0]  m, m_noise;
        logic [23:0] c, c_noise;
        logic        en;
        sys_rst = 1'b1; en_i = 1'b1; mode_i = 2'd0; color_i = 24'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        hold_reset(3);
        sys_rst = 1'b0;
        phase_done("reset");

        // One frame per pattern; a mid-frame input change must be ignored until the next frame.
        for (int f = 0; f < 4; f++) begin
            m = 2'(f);
            c = 24'($urandom);
            for (int i = 0; i < FRAME; i++) begin
                if (i == FRAME / 3) begin
                    m = 2'($urandom);
                    c = 24'($urandom);
                end
                step(1'b1, m, c);
            end
            phase_done($sformatf("frame_mode%0d", f));
        end

        // Enable dropped for 3 clocks mid-frame restarts the frame at (0,0).
        m = 2'd1; c = 24'h123456;
        for (int i = 0; i < FRAME / 2; i++) step(1'b1, m, c);
        for (int i = 0; i < 3; i++) step(1'b0, m, c);
        m = 2'd2;
        for (int i = 0; i < FRAME + 10; i++) step(1'b1, m, c);
        phase_done("enable_gap");

        // Random enable glitches and pattern changes.
        m = 2'd3; c = 24'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                m = 2'($urandom);
                c = 24'($urandom);
            end
            en = ($urandom_range(0, 99) >= 2);
            m_noise = m; c_noise = c;
            step(en, m_noise, c_noise);
        end
        phase_done("random_enable");

        // Asynchronous reset mid-line, then restart from (0,0) with frame count cleared.
        m = 2'd0; c = 24'hA5C33C;
        for (int i = 0; i < 1000; i++) step(1'b1, m, c);
        reset_mid();
        m = 2'd3;
        for (int i = 0; i < FRAME + 5; i++) step(1'b1, m, c);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) check("queue_drain", edge_n, 45'(exp_q.size()), 45'h0);
        phase_done("reset_mid");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
